nvdla_csb_reg_slave: RTL
========================

Name: nvdla_csb_reg_slave

Overview:
- CSB responder (slave end) of the NVDLA configuration-space bus. Terminates CSB requests from an upstream CSB master into a local bank of 32-bit configuration registers.
- Serves reads, posted writes and non-posted writes, one transaction outstanding at a time.
- Sits behind the CSB master port of the HWPE/NVDLA glue logic. Exposes register contents and per-register write strobes to local datapath logic.

Parameters:
- BASE_ADDR, 16'h0000, CSB word address of register 0.
- NUM_REGS, 8, number of 32-bit registers; range 1..64.
- RESP_LAT, 1, cycles from request acceptance to r_valid/wr_complete pulse; range 1..15.
- RST_VAL, 32'h0, reset value of every register.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- rst_ni  in  1  asynchronous active-low reset.
- csb_valid_i  in  1  request valid.
- csb_ready_o  out  1  request ready.
- csb_addr_i  in  16  CSB word address.
- csb_wdat_i  in  32  write data.
- csb_write_i  in  1  1 = write, 0 = read.
- csb_nposted_i  in  1  write requires wr_complete; ignored for reads.
- csb_r_valid_o  out  1  read data valid, single-cycle pulse.
- csb_r_data_o  out  32  read data.
- csb_wr_complete_o  out  1  non-posted write done, single-cycle pulse.
- reg_q_o  out  NUM_REGS*32  register contents; register i at bits [32*i+31:32*i].
- reg_we_o  out  NUM_REGS  one-cycle strobe, asserted the cycle after register i is written.

Behaviour:
- Reset values: csb_ready_o=1, csb_r_valid_o=0, csb_r_data_o=0, csb_wr_complete_o=0, reg_we_o=0, all registers=RST_VAL, FSM=IDLE, latency counter=0.
- Accept means csb_valid_i && csb_ready_o at a rising edge.
- Decode: idx = csb_addr_i - BASE_ADDR, computed as a 16-bit unsigned subtraction. A hit is idx < NUM_REGS. Addresses below BASE_ADDR wrap to large values and therefore miss.
- FSM states: IDLE, WAIT.
  - IDLE: csb_ready_o=1.
  - Posted write accepted: on a hit, the register updates at the accept edge and reg_we_o[idx] pulses the next cycle. Remain in IDLE, so back-to-back posted writes run at one per cycle.
  - Read or non-posted write accepted: on a hit, the write (if any) commits at the accept edge. Read data is captured at the accept edge; a miss captures 0. Load counter = RESP_LAT-1 and go to WAIT.
  - WAIT: csb_ready_o=0. Counter decrements each cycle. When counter==0, drive the single-cycle response pulse and return to IDLE. csb_ready_o=1 from the cycle after the pulse.
- Response timing: accept at edge N gives the pulse in cycle N+RESP_LAT. Total accept-to-accept spacing for reads is RESP_LAT+1 cycles.
- Read response: csb_r_valid_o=1 with csb_r_data_o holding the captured data. csb_r_data_o keeps its value after the pulse until the next read response.
- Non-posted write response: csb_wr_complete_o=1 for one cycle. csb_r_valid_o stays 0.
- Miss handling: a write is dropped with no reg_we_o pulse. A non-posted write still returns wr_complete. A read returns 0. No hang is permitted on any address.
- The response channel has no back-pressure. Pulses are never repeated or stretched.
- csb_valid_i while in WAIT is not accepted. The request fields must be held by the master per the CSB handshake.
- Reads return the register value before any same-cycle write; only one transaction can be accepted per edge.
- Reset asserted mid-transaction: the pending response is discarded with no pulse, and all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: NVDLA_CSB_ERR_CNT_EN.
- When defined:
  - An extra read-only register at word address BASE_ADDR+NUM_REGS holds a 16-bit saturating count of accepted miss accesses, in bits [15:0]; bits [31:16] read 0.
  - The counter saturates at 16'hFFFF.
  - Writes to this address clear the counter. Such writes pulse no reg_we_o bit and do not count as misses.
  - Reset value is 0.
- When undefined: that address is an ordinary miss, and no counter logic is synthesized.

Test Plan:
- Reset then read BASE_ADDR+3, RESP_LAT=1 -> ready=1 out of reset; r_valid pulse exactly one cycle after accept with r_data=32'h0; ready low for 1 cycle.
- Posted writes to regs 0,1,2 on consecutive cycles (data 32'hA5A50000+i) -> ready stays 1; reg_we_o pulses 3'b001, 3'b010, 3'b100 in successive cycles; reg_q_o fields updated; no wr_complete.
- Non-posted write 32'hDEADBEEF to reg 7, RESP_LAT=3 -> wr_complete pulse 3 cycles after accept; ready low for those 3 cycles; readback returns 32'hDEADBEEF.
- Read of BASE_ADDR-1 and BASE_ADDR+NUM_REGS+5 (macro off) -> r_data=0; a non-posted write to the same addresses -> wr_complete only, reg_q_o unchanged.
- Reset asserted during WAIT of a RESP_LAT=4 read -> no r_valid pulse; all outputs at reset values; next read completes normally.
- Macro on: 3 miss accesses, then read BASE_ADDR+NUM_REGS -> 32'h3; write there, then read again -> 32'h0.

Source files
------------

// File: rtl/nvdla_csb_reg_slave.sv
// nvdla_csb_reg_slave: CSB responder terminating config requests into a local 32-bit register bank.
// Optional saturating miss counter at BASE_ADDR+NUM_REGS, enabled by NVDLA_CSB_ERR_CNT_EN.
module nvdla_csb_reg_slave #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          NUM_REGS  = 8,
    parameter int          RESP_LAT  = 1,
    parameter logic [31:0] RST_VAL   = 32'h0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     csb_valid_i,
    output logic                     csb_ready_o,
    input  logic [15:0]              csb_addr_i,
    input  logic [31:0]              csb_wdat_i,
    input  logic                     csb_write_i,
    input  logic                     csb_nposted_i,
    output logic                     csb_r_valid_o,
    output logic [31:0]              csb_r_data_o,
    output logic                     csb_wr_complete_o,
    output logic [NUM_REGS*32-1:0]   reg_q_o,
    output logic [NUM_REGS-1:0]      reg_we_o
);
    typedef enum logic {IDLE, WAIT} state_e;
    state_e              r_state, w_state_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic                r_wr_pend;
    logic [31:0]         r_cap, r_hold;
    logic [31:0]         r_regs [NUM_REGS];
    logic [15:0]         w_idx;
    logic [NUM_REGS-1:0] w_sel;
    logic [31:0]         w_rdata, w_cap_d;
    logic                w_acc, w_slow, w_resp;
    assign w_idx = csb_addr_i - BASE_ADDR;
    assign csb_ready_o = (r_state == IDLE);
    assign w_acc = csb_valid_i && csb_ready_o;
    assign w_slow = !csb_write_i || csb_nposted_i;
    assign w_resp = (r_state == WAIT) && (r_cnt == 4'd0);
    assign csb_r_valid_o = w_resp && !r_wr_pend;
    assign csb_wr_complete_o = w_resp && r_wr_pend;
    // The captured word is shown only during the pulse; afterwards the last delivered word is held.
    assign csb_r_data_o = csb_r_valid_o ? r_cap : r_hold;
    always_comb begin
        w_sel = '0;
        w_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_sel[i] = (w_idx == 16'(i));
            w_rdata = w_sel[i] ? r_regs[i] : w_rdata;
        end
    end
`ifdef NVDLA_CSB_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic        w_err_addr;
    assign w_err_addr = (w_idx == 16'(NUM_REGS));
    assign w_cap_d = w_err_addr ? {16'h0, r_err_cnt} : w_rdata;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_err_cnt <= '0;
        else if (w_acc && w_err_addr && csb_write_i)
            r_err_cnt <= '0;
        else if (w_acc && !(|w_sel) && !w_err_addr && r_err_cnt != 16'hFFFF)
            r_err_cnt <= r_err_cnt + 16'd1;
    end
`else
    assign w_cap_d = w_rdata;
`endif
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt = r_cnt;
        if (r_state == IDLE) begin
            w_state_nxt = (w_acc && w_slow) ? WAIT : IDLE;
            w_cnt_nxt = (w_acc && w_slow) ? 4'(RESP_LAT - 1) : r_cnt;
        end else begin
            w_state_nxt = (r_cnt == 4'd0) ? IDLE : WAIT;
            w_cnt_nxt = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wr_pend <= 1'b0;
            r_cap     <= '0;
            r_hold    <= '0;
            reg_we_o  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            reg_we_o <= (w_acc && csb_write_i) ? w_sel : '0;
            if (w_acc && w_slow)
                r_wr_pend <= csb_write_i;
            if (w_acc && !csb_write_i)
                r_cap <= w_cap_d;
            if (csb_r_valid_o)
                r_hold <= r_cap;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= RST_VAL;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (w_acc && csb_write_i && w_sel[i])
                    r_regs[i] <= csb_wdat_i;
        end
    end
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign reg_q_o[32*g +: 32] = r_regs[g];
    end
endmodule
